cu_sequencer: RTL

Host-side control sequencer that drives one ComputeUnit through a complete job: it accepts a job command, shifts the configuration words into the CU under `io_config_enable`, and asserts `io_enable` until the CU raises `io_done`. It then captures `io_scalarOut` and returns it to the host on a valid/ready response channel. The block is the master end of the CU's enable/config/done interface and sits between the fabric controller and each CU instance.

---
 rtl/cu_seq_pkg.sv | 16 +
 rtl/cu_sequencer_if.sv | 34 +++
 rtl/cu_seq_watchdog.sv | 38 +++
 rtl/cu_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cu_seq_pkg.sv
// Shared types and default sizes for the ComputeUnit job sequencer.
package cu_seq_pkg;

  // Job phases: wait for a command, stream config words, run the CU,
  // then hold the result until the host takes it.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    RUN    = 2'd2,
    RESP   = 2'd3
  } cu_seq_state_t;

  localparam int CU_DATA_W    = 7;
  localparam int CU_CFG_WORDS = 4;

endpackage

// File: rtl/cu_sequencer_if.sv
// Host command/response channel plus the CU enable/config/done bundle.
// The master modport is the sequencer side; the slave modport is the
// host/CU side that the sequencer talks to.
interface cu_sequencer_if
  import cu_seq_pkg::*;
#(
  parameter int DATA_W    = CU_DATA_W,
  parameter int CFG_WORDS = CU_CFG_WORDS
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [CFG_WORDS*DATA_W-1:0] cmd_cfg;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [DATA_W-1:0]           rsp_data;
  logic                        rsp_timeout;
  logic                        io_config_enable;
  logic [DATA_W-1:0]           io_config_data;
  logic                        io_enable;
  logic                        io_done;
  logic [DATA_W-1:0]           io_scalarOut;

  modport master (
    input  cmd_valid, cmd_cfg, rsp_ready, io_done, io_scalarOut,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout,
           io_config_enable, io_config_data, io_enable
  );

  modport slave (
    output cmd_valid, cmd_cfg, rsp_ready, io_done, io_scalarOut,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout,
           io_config_enable, io_config_data, io_enable
  );
endinterface

// File: rtl/cu_seq_watchdog.sv
// RUN-phase watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the count sits at TIMEOUT-1.
module cu_seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear on job acceptance, otherwise count every RUN cycle.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = count_en && (count_q == LAST);

endmodule

// File: rtl/cu_sequencer.sv
// Drives one ComputeUnit through a job: accept a command, shift the
// config words in, run until io_done, return io_scalarOut to the host.
// Optional feature macro: CU_SEQ_TIMEOUT_EN adds a RUN watchdog that
// aborts the job after TIMEOUT cycles with rsp_timeout set.
module cu_sequencer
  import cu_seq_pkg::*;
#(
  parameter int DATA_W    = CU_DATA_W,
  parameter int CFG_WORDS = CU_CFG_WORDS,
  parameter int TIMEOUT   = 64
) (
  input  logic          clk,
  input  logic          reset,
  cu_sequencer_if.master bus
);
  localparam int IDX_W = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CFG_WORDS - 1);

  cu_seq_state_t state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [CFG_WORDS*DATA_W-1:0] cfg_q, cfg_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]           rsp_data_q, rsp_data_d;
  logic                        rsp_timeout_q, rsp_timeout_d;
  logic                        cfg_en_q, cfg_en_d;
  logic [DATA_W-1:0]           cfg_data_q, cfg_data_d;
  logic                        run_en_q, run_en_d;
  logic                        accept;
  logic                        expired;

  // Latched payload viewed as an array of words for indexed selection.
  logic [DATA_W-1:0] cfg_words [CFG_WORDS];
  for (genvar gi = 0; gi < CFG_WORDS; gi++) begin : g_word
    assign cfg_words[gi] = cfg_q[gi*DATA_W +: DATA_W];
  end

`ifdef CU_SEQ_TIMEOUT_EN
  cu_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .count_en (state_q == RUN),
    .expired  (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Next state and next registered outputs; every output is a flop so
  // each value describes what the pins show in the following cycle.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cfg_d         = cfg_q;
    cmd_ready_d   = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    cfg_en_d      = 1'b0;
    cfg_data_d    = '0;
    run_en_d      = 1'b0;
    accept        = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          // First word comes straight from the command so the strobe
          // starts the cycle after acceptance.
          accept      = 1'b1;
          cfg_d       = bus.cmd_cfg;
          idx_d       = '0;
          state_d     = CONFIG;
          cmd_ready_d = 1'b0;
          cfg_en_d    = 1'b1;
          cfg_data_d  = bus.cmd_cfg[DATA_W-1:0];
        end
      end
      CONFIG: begin
        // idx_q is the word on the pins this cycle.
        if (idx_q == LAST_IDX) begin
          state_d  = RUN;
          run_en_d = 1'b1;
        end else begin
          idx_d      = idx_q + 1'b1;
          cfg_en_d   = 1'b1;
          cfg_data_d = cfg_words[idx_d];
        end
      end
      RUN: begin
        run_en_d = 1'b1;
        if (bus.io_done) begin
          // Completion takes priority over a same-cycle watchdog expiry.
          state_d       = RESP;
          run_en_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = bus.io_scalarOut;
          rsp_timeout_d = 1'b0;
        end else if (expired) begin
          state_d       = RESP;
          run_en_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
        end
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight job.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cfg_q         <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cfg_en_q      <= 1'b0;
      cfg_data_q    <= '0;
      run_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cfg_q         <= cfg_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      cfg_en_q      <= cfg_en_d;
      cfg_data_q    <= cfg_data_d;
      run_en_q      <= run_en_d;
    end
  end

  assign bus.cmd_ready        = cmd_ready_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_data         = rsp_data_q;
  assign bus.io_config_enable = cfg_en_q;
  assign bus.io_config_data   = cfg_data_q;
  assign bus.io_enable        = run_en_q;
`ifdef CU_SEQ_TIMEOUT_EN
  assign bus.rsp_timeout      = rsp_timeout_q;
`else
  assign bus.rsp_timeout      = 1'b0;
`endif

endmodule
